// File: rtl/pixel_line_sequencer.sv
// Frame sequencer for the pixel line buffer: one trigger window per line,
// ping-pong over two SRAM banks, each filled bank handed to DMA in capture order.
module pixel_line_sequencer #(
  parameter int MAX_W = 4088
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start_i,
  input  logic        frame_abort_i,
  input  logic [11:0] image_width_i,
  input  logic [11:0] image_height_i,
  output logic        pixel_trigger_o,
  input  logic        pixel_trigger_done_i,
  output logic        pixel_bank_o,
  output logic        dma_req_o,
  output logic        dma_bank_o,
  output logic [9:0]  dma_words_o,
  output logic [11:0] dma_line_o,
  input  logic        dma_ack_i,
  input  logic        dma_done_i,
  output logic        busy_o,
  output logic        frame_done_o,
  output logic [11:0] line_cnt_o,
  output logic        zero_cfg_o
);
  typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DRAIN} state_t;
  localparam logic [11:0] MAX_W12 = 12'(MAX_W);

  state_t           state, state_nx;
  logic [11:0]      width_q, height_q;
  logic [1:0]       bank_full, bank_full_nx;
  logic [1:0][11:0] bank_line;
  logic             rd_bank, dma_pend;
  logic             start_ok, line_done, bank_free, dma_issue;

  // pixel_bank_o doubles as the write-bank pointer, line_cnt_o as the line counter
  assign start_ok  = frame_start_i && (image_width_i != '0) && (image_height_i != '0);
  assign line_done = (state == CAPTURE) && pixel_trigger_done_i;
  assign bank_free = dma_done_i && dma_pend;
  assign dma_issue = !dma_req_o && !dma_pend && bank_full[rd_bank];

  always_comb begin
    bank_full_nx = bank_full;
    if (bank_free) bank_full_nx[rd_bank] = 1'b0;
    if (line_done) bank_full_nx[pixel_bank_o] = 1'b1;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_ok) state_nx = ARM;
      ARM:     if (!bank_full[pixel_bank_o]) state_nx = CAPTURE;
      CAPTURE: if (pixel_trigger_done_i)
                 state_nx = ((line_cnt_o + 12'd1) == height_q) ? DRAIN : ARM;
      DRAIN:   if ((bank_full == 2'b00) && !dma_pend) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (frame_abort_i) state_nx = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      width_q         <= '0;
      height_q        <= '0;
      bank_full       <= '0;
      bank_line       <= '0;
      rd_bank         <= 1'b0;
      dma_pend        <= 1'b0;
      pixel_trigger_o <= 1'b0;
      pixel_bank_o    <= 1'b0;
      dma_req_o       <= 1'b0;
      dma_bank_o      <= 1'b0;
      dma_words_o     <= '0;
      dma_line_o      <= '0;
      busy_o          <= 1'b0;
      frame_done_o    <= 1'b0;
      line_cnt_o      <= '0;
      zero_cfg_o      <= 1'b0;
    end else begin
      state           <= state_nx;
      busy_o          <= (state_nx != IDLE);
      pixel_trigger_o <= (state_nx == CAPTURE);
      frame_done_o    <= (state == DRAIN) && (state_nx == IDLE) && !frame_abort_i;
      if (frame_abort_i) begin
        // line_cnt_o and bank pointers are left as they were for debug
        bank_full <= '0;
        dma_pend  <= 1'b0;
        dma_req_o <= 1'b0;
      end else begin
        bank_full <= bank_full_nx;
        if ((state == IDLE) && frame_start_i) begin
          if (start_ok) begin
            width_q      <= (image_width_i > MAX_W12) ? MAX_W12 : image_width_i;
            height_q     <= image_height_i;
            line_cnt_o   <= '0;
            pixel_bank_o <= 1'b0;
            rd_bank      <= 1'b0;
            zero_cfg_o   <= 1'b0;
          end else begin
            zero_cfg_o <= 1'b1;
          end
        end
        if (line_done) begin
          bank_line[pixel_bank_o] <= line_cnt_o;
          line_cnt_o              <= line_cnt_o + 12'd1;
          pixel_bank_o            <= ~pixel_bank_o;
        end
        if (dma_issue) begin
          dma_req_o   <= 1'b1;
          dma_bank_o  <= rd_bank;
          dma_line_o  <= bank_line[rd_bank];
          dma_words_o <= 10'((width_q + 12'd7) >> 3);
        end else if (dma_req_o && dma_ack_i) begin
          dma_req_o <= 1'b0;
          dma_pend  <= 1'b1;
        end
        if (bank_free) begin
          dma_pend <= 1'b0;
          rd_bank  <= ~rd_bank;
        end
      end
    end
  end
endmodule

// File: tb/tb_pixel_line_sequencer.sv
// Bench for pixel_line_sequencer: line/drain-count model checked every cycle,
// plus directed frames with hand-computed timing and word counts.
module tb_pixel_line_sequencer;
  logic clk = 1'b0, rst = 1'b1;
  logic frame_start_i = 1'b0, frame_abort_i = 1'b0;
  logic [11:0] image_width_i = '0, image_height_i = '0;
  logic pixel_trigger_done_i = 1'b0, dma_ack_i = 1'b0, dma_done_i = 1'b0;
  logic pixel_trigger_o, pixel_bank_o, dma_req_o, dma_bank_o, busy_o, frame_done_o, zero_cfg_o;
  logic [9:0]  dma_words_o;
  logic [11:0] dma_line_o, line_cnt_o;

  always #5 clk = ~clk;

  pixel_line_sequencer dut (
    .clk(clk), .rst(rst), .frame_start_i(frame_start_i), .frame_abort_i(frame_abort_i),
    .image_width_i(image_width_i), .image_height_i(image_height_i),
    .pixel_trigger_o(pixel_trigger_o), .pixel_trigger_done_i(pixel_trigger_done_i),
    .pixel_bank_o(pixel_bank_o), .dma_req_o(dma_req_o), .dma_bank_o(dma_bank_o),
    .dma_words_o(dma_words_o), .dma_line_o(dma_line_o), .dma_ack_i(dma_ack_i),
    .dma_done_i(dma_done_i), .busy_o(busy_o), .frame_done_o(frame_done_o),
    .line_cnt_o(line_cnt_o), .zero_cfg_o(zero_cfg_o)
  );

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  function automatic int qi(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // Model: counts of lines captured, requests acked, banks drained this frame
  int m_lines = 0, m_reqd = 0, m_drained = 0, m_h = 0, m_words = 0, m_cd = 0;
  bit m_active = 0, m_zero = 0, m_fd = 0, m_cap_prev = 0, m_ack_prev = 0;
  bit trig_ok, req_ok;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      m_lines = 0; m_reqd = 0; m_drained = 0; m_h = 0; m_words = 0; m_cd = 0;
      m_active = 0; m_zero = 0; m_cap_prev = 0; m_ack_prev = 0;
    end
    m_fd = 0;
    if (m_cd > 0) begin
      m_cd--;
      if (m_cd == 0) begin m_active = 0; m_fd = 1; end
    end
    chk("busy", busy_o, m_active);
    chk("frame_done", frame_done_o, m_fd);
    chk("line_cnt", line_cnt_o, m_lines);
    chk("zero_cfg", zero_cfg_o, m_zero);
    chk("pixel_bank", pixel_bank_o, m_lines % 2);
    // a window may open only for an uncaptured line into a free bank, never right after a line
    trig_ok = m_active && (m_cd == 0) && (m_lines < m_h) && ((m_lines - m_drained) < 2) && !m_cap_prev;
    chk("trig_illegal", pixel_trigger_o && !trig_ok, 0);
    req_ok = m_active && (m_reqd < m_lines) && (m_reqd == m_drained) && !m_ack_prev;
    chk("req_illegal", dma_req_o && !req_ok, 0);
    if (dma_req_o) begin
      chk("dma_line", dma_line_o, m_reqd);
      chk("dma_bank", dma_bank_o, m_reqd % 2);
      chk("dma_words", dma_words_o, m_words);
    end
    m_cap_prev = 0; m_ack_prev = 0;
    if (!rst) begin
      if (frame_abort_i) begin
        m_active = 0; m_cd = 0; m_reqd = m_lines; m_drained = m_lines;
      end else begin
        if (frame_start_i && !m_active) begin
          if (image_width_i != 0 && image_height_i != 0) begin
            m_active = 1; m_lines = 0; m_reqd = 0; m_drained = 0; m_zero = 0;
            m_h = int'(image_height_i);
            m_words = ((image_width_i > 4088 ? 4088 : int'(image_width_i)) + 7) / 8;
          end else m_zero = 1;
        end
        if (pixel_trigger_o && pixel_trigger_done_i) begin m_lines++; m_cap_prev = 1; end
        if (dma_done_i && (m_reqd > m_drained)) begin
          m_drained++;
          if (m_active && m_drained == m_h) m_cd = 2;
        end
        if (dma_req_o && dma_ack_i) begin m_reqd++; m_ack_prev = 1; end
      end
    end
  end

  // Pixel buffer and DMA responders plus event recording
  int cyc = 0, pix_lat = 3, ack_lat = 2, done_lat = 20;
  bit pix_auto = 1, ack_en = 1;
  int trig_age = 0, req_age = 0, dwait = 0, fd_cnt = 0;
  bit prev_trig = 0, prev_req = 0;
  int trig_cyc[$], trig_bank[$], req_cyc[$], req_line[$], req_words[$], req_bank[$], done_cyc[$];

  task automatic clear_log();
    trig_cyc.delete(); trig_bank.delete(); req_cyc.delete(); req_line.delete();
    req_words.delete(); req_bank.delete(); done_cyc.delete();
  endtask

  task automatic tick();
    @(posedge clk); #2; cyc++;
    if (pixel_trigger_o && !prev_trig) begin trig_cyc.push_back(cyc); trig_bank.push_back(int'(pixel_bank_o)); end
    if (dma_req_o && !prev_req) begin
      req_cyc.push_back(cyc); req_line.push_back(int'(dma_line_o));
      req_words.push_back(int'(dma_words_o)); req_bank.push_back(int'(dma_bank_o));
    end
    if (frame_done_o) fd_cnt++;
    prev_trig = pixel_trigger_o; prev_req = dma_req_o;
    if (dma_ack_i) dwait = done_lat;
    trig_age = pixel_trigger_o ? trig_age + 1 : 0;
    req_age  = dma_req_o ? req_age + 1 : 0;
    pixel_trigger_done_i = pix_auto && pixel_trigger_o && (trig_age == pix_lat);
    dma_ack_i = ack_en && dma_req_o && (req_age == ack_lat);
    dma_done_i = 1'b0;
    if (dwait > 0) begin
      dwait--;
      if (dwait == 0) begin dma_done_i = 1'b1; done_cyc.push_back(cyc); end
    end
    frame_start_i = 1'b0; frame_abort_i = 1'b0;
  endtask

  task automatic start(input int w, input int h);
    image_width_i = 12'(w); image_height_i = 12'(h); frame_start_i = 1'b1;
  endtask

  task automatic run_frame(input string nm, input int budget);
    int f0 = fd_cnt;
    int n = 0;
    while (fd_cnt == f0 && n < budget) begin tick(); n++; end
    repeat (3) tick();
    chk({nm, "_frame_done_count"}, fd_cnt - f0, 1);
  endtask

  int s, k, d0;
  int wl[4], wexp[4];

  initial begin
    wl = '{9, 4088, 1, 4095}; wexp = '{2, 511, 1, 511};
    repeat (2) tick();
    chk("rst_busy", busy_o, 0); chk("rst_trig", pixel_trigger_o, 0);
    chk("rst_req", dma_req_o, 0); chk("rst_line_cnt", line_cnt_o, 0);
    rst = 1'b0;
    tick();

    // Basic frame: 16 px x 4 lines
    clear_log(); pix_lat = 3; ack_lat = 2; done_lat = 20;
    start(16, 4); s = cyc;
    tick(); chk("t1_arm_trig", pixel_trigger_o, 0); chk("t1_busy", busy_o, 1);
    tick(); chk("t1_trig_at_T+2", pixel_trigger_o, 1);
    run_frame("t1", 500);
    chk("t1_windows", trig_bank.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_win_bank", qi(trig_bank, i), i % 2);
      chk("t1_req_line", qi(req_line, i), i);
      chk("t1_req_words", qi(req_words, i), 2);
    end
    chk("t1_next_trig_gap", qi(trig_cyc, 1) - qi(trig_cyc, 0), 4);
    chk("t1_first_req_gap", qi(req_cyc, 0) - qi(trig_cyc, 0), 4);
    chk("t1_line_cnt", line_cnt_o, 4);
    chk("t1_busy_end", busy_o, 0);

    // Backpressure: done withheld 200 cycles, ARM must wait for bank 0
    clear_log(); done_lat = 200;
    start(8, 4);
    run_frame("t2", 1500);
    d0 = (done_cyc.size() > 0) ? done_cyc[0] : -100;
    k = 0;
    foreach (trig_cyc[i]) if (trig_cyc[i] < d0) k++;
    chk("t2_windows_before_done", k, 2);
    chk("t2_trig_at_D+2", qi(trig_cyc, 2) - d0, 2);
    chk("t2_bank_after_done", qi(trig_bank, 2), 0);
    chk("t2_line_cnt", line_cnt_o, 4);

    // Word rounding / clamping, height 1
    done_lat = 3;
    for (int i = 0; i < 4; i++) begin
      clear_log();
      start(wl[i], 1);
      run_frame("t3", 200);
      chk("t3_words", qi(req_words, 0), wexp[i]);
      chk("t3_line", qi(req_line, 0), 0);
      chk("t3_windows", trig_bank.size(), 1);
    end

    // Zero configuration
    start(16, 0); tick(); tick();
    chk("t4_busy_h0", busy_o, 0); chk("t4_zero_h0", zero_cfg_o, 1);
    start(0, 5); tick();
    chk("t4_busy_w0", busy_o, 0); chk("t4_zero_w0", zero_cfg_o, 1);
    clear_log(); start(8, 2); tick();
    chk("t4_zero_clr", zero_cfg_o, 0); chk("t4_busy_ok", busy_o, 1);
    run_frame("t4", 300);

    // Abort during line 2 with an unacked request outstanding
    clear_log(); pix_lat = 30; done_lat = 5; ack_en = 1;
    start(16, 4);
    k = 0;
    while (!(line_cnt_o == 2 && pixel_trigger_o) && k < 400) begin tick(); k++; end
    chk("t5_reached_line2", line_cnt_o == 2 && pixel_trigger_o, 1);
    ack_en = 0;
    k = 0;
    while (!dma_req_o && k < 20) begin tick(); k++; end
    chk("t5_req_pending", dma_req_o, 1);
    chk("t5_still_capturing", pixel_trigger_o, 1);
    s = fd_cnt;
    frame_abort_i = 1'b1; tick();
    chk("t5_trig", pixel_trigger_o, 0); chk("t5_req", dma_req_o, 0);
    chk("t5_busy", busy_o, 0); chk("t5_line_cnt_held", line_cnt_o, 2);
    repeat (3) tick();
    chk("t5_no_frame_done", fd_cnt - s, 0);
    dwait = 0; ack_en = 1; pix_lat = 3; done_lat = 20; clear_log();
    start(16, 2);
    run_frame("t5_restart", 300);
    chk("t5_restart_bank0", qi(trig_bank, 0), 0);
    chk("t5_restart_req0", qi(req_line, 0), 0);
    chk("t5_restart_req1", qi(req_line, 1), 1);

    // Reset while draining
    clear_log(); start(16, 2);
    k = 0;
    while (!(line_cnt_o == 2 && busy_o) && k < 200) begin tick(); k++; end
    chk("t6_in_drain", line_cnt_o == 2 && busy_o, 1);
    #1 rst = 1'b1; #1;
    chk("t6_rst_busy", busy_o, 0); chk("t6_rst_line_cnt", line_cnt_o, 0);
    chk("t6_rst_trig", pixel_trigger_o, 0); chk("t6_rst_req", dma_req_o, 0);
    dwait = 0;
    tick(); tick();
    rst = 1'b0;
    dma_done_i = 1'b1; tick();
    repeat (3) tick();
    chk("t6_stray_busy", busy_o, 0); chk("t6_stray_req", dma_req_o, 0);
    clear_log(); done_lat = 5;
    start(8, 1);
    run_frame("t6_after", 200);
    chk("t6_after_bank", qi(req_bank, 0), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
